// File: rtl/fb_flag_ctrl.sv
// Flag-register write controller: arbitrates ALU/CSR flag updates, 1-cycle write latency, tracks reservations.
// Readies only in RUN; define FB_FLAG_RR_EN for round-robin conflict arbitration (default: CSR wins).
module fb_flag_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_valid,
  input  logic [3:0] alu_nzcv,
  output logic       alu_ready,
  input  logic       csr_valid,
  input  logic [3:0] csr_nzcv,
  output logic       csr_ready,
  input  logic       rsv,
  input  logic       hold,
  input  logic       flush,
  output logic       flag_we,
  output logic [3:0] flag_nzcv,
  output logic       flags_busy,
  output logic       rsv_full
);

  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] cnt;
  logic       grant_csr;
  logic       xfer;
  logic [3:0] xfer_nzcv;

`ifdef FB_FLAG_RR_EN
  logic rr_ptr;  // 0 = ALU wins next conflict, 1 = CSR wins

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= 1'b0;
    else if (state == RUN && alu_valid && csr_valid)
      rr_ptr <= ~rr_ptr;
  end

  assign grant_csr = csr_valid && (!alu_valid || rr_ptr);
`else
  assign grant_csr = csr_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)
      state_nxt = FLUSH;
    else begin
      case (state)
        RUN:     state_nxt = hold ? HOLD : RUN;
        HOLD:    state_nxt = hold ? HOLD : RUN;
        FLUSH:   state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    alu_ready = 1'b0;
    csr_ready = 1'b0;
    if (state == RUN) begin
      csr_ready = grant_csr;
      alu_ready = alu_valid && !grant_csr;
    end
  end

  assign xfer      = alu_ready || csr_ready;
  assign xfer_nzcv = csr_ready ? csr_nzcv : alu_nzcv;

  // A transfer accepted while flush is sampled is dropped, not written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_we   <= 1'b0;
      flag_nzcv <= 4'b0000;
    end else begin
      flag_we <= xfer && !flush;
      if (xfer && !flush)
        flag_nzcv <= xfer_nzcv;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= 3'd0;
    else if (flush || state == FLUSH)
      cnt <= 3'd0;
    else if (state == RUN) begin
      if (rsv && xfer)
        cnt <= cnt;
      else if (rsv && cnt != 3'd7)
        cnt <= cnt + 3'd1;
      else if (xfer && cnt != 3'd0)
        cnt <= cnt - 3'd1;
    end
  end

  assign flags_busy = (cnt != 3'd0) || flag_we;
  assign rsv_full   = (cnt == 3'd7);

endmodule

// File: tb/tb_fb_flag_ctrl.sv
// Randomized + directed bench for fb_flag_ctrl against a transaction-level reference model.
module tb_fb_flag_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_valid, csr_valid, rsv, hold, flush;
  logic [3:0] alu_nzcv, csr_nzcv;
  logic       alu_ready, csr_ready, flag_we, flags_busy, rsv_full;
  logic [3:0] flag_nzcv;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: 0 = running, 1 = held, 2 = flushing
  int         m_mode;
  int         m_cnt;
  logic       m_we;
  logic [3:0] m_nzcv;
  logic       m_ptr;

  fb_flag_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_nzcv(alu_nzcv), .alu_ready(alu_ready),
    .csr_valid(csr_valid), .csr_nzcv(csr_nzcv), .csr_ready(csr_ready),
    .rsv(rsv), .hold(hold), .flush(flush),
    .flag_we(flag_we), .flag_nzcv(flag_nzcv),
    .flags_busy(flags_busy), .rsv_full(rsv_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_we = 1'b0; m_nzcv = 4'b0000; m_ptr = 1'b0;
  endtask

  // One clock cycle: drive, check readies, clock, update model, check registered outputs.
  task automatic cyc(input logic av, input logic [3:0] an, input logic cv, input logic [3:0] cn,
                     input logic r, input logic h, input logic f);
    logic e_a, e_c, acc;
    alu_valid = av; alu_nzcv = an; csr_valid = cv; csr_nzcv = cn;
    rsv = r; hold = h; flush = f;
    #1;
    e_a = 1'b0; e_c = 1'b0;
    if (m_mode == 0) begin
      if (av && cv) begin
`ifdef FB_FLAG_RR_EN
        if (m_ptr) e_c = 1'b1; else e_a = 1'b1;
`else
        e_c = 1'b1;
`endif
      end else begin
        e_a = av; e_c = cv;
      end
    end
    chk("alu_ready", alu_ready, e_a);
    chk("csr_ready", csr_ready, e_c);
    @(posedge clk);
    acc = e_a | e_c;
    m_we = acc && !f;
    if (m_we) m_nzcv = e_c ? cn : an;
    if (f || m_mode == 2)
      m_cnt = 0;
    else if (m_mode == 0) begin
      if (r && acc) m_cnt = m_cnt;
      else if (r) m_cnt = (m_cnt + 1 > 7) ? 7 : m_cnt + 1;
      else if (acc) m_cnt = (m_cnt - 1 < 0) ? 0 : m_cnt - 1;
    end
    if (m_mode == 0 && av && cv) m_ptr = !m_ptr;
    if (f) m_mode = 2;
    else if (m_mode == 2) m_mode = 0;
    else m_mode = h ? 1 : 0;
    #1;
    chk("flag_we", flag_we, m_we);
    chk("flag_nzcv", flag_nzcv, m_nzcv);
    chk("flags_busy", flags_busy, (m_cnt != 0) || m_we);
    chk("rsv_full", rsv_full, m_cnt == 7);
  endtask

  task automatic idle();
    cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] saved;
    rst_n = 1'b0;
    alu_valid = 1'b0; csr_valid = 1'b0; alu_nzcv = 4'h0; csr_nzcv = 4'h0;
    rsv = 1'b0; hold = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flag_we", flag_we, 1'b0);
    chk("rst_flag_nzcv", flag_nzcv, 4'b0000);
    chk("rst_busy", flags_busy, 1'b0);
    chk("rst_full", rsv_full, 1'b0);
    rst_n = 1'b1;

    // Lone ALU update
    cyc(1'b1, 4'b1010, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("alu_alone_nzcv", flag_nzcv, 4'b1010);
    idle();

    // Three cycles of conflict
    repeat (3) cyc(1'b1, 4'b0001, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
    idle();

    // Reservation saturation and drain
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      if (i >= 6) chk("rsv_full_sat", rsv_full, 1'b1);
    end
    cyc(1'b1, 4'b0011, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("rsv_xfer_full", rsv_full, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'(i), 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("drain_busy_we", flags_busy, 1'b1);
    idle();
    chk("drain_busy_clear", flags_busy, 1'b0);

    // Hold freezes requests
    repeat (3) cyc(1'b1, 4'b0110, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 4'b0110, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'b0110, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("post_hold_we", flag_we, 1'b1);
    idle();

    // Flush drops a CSR write accepted in the same cycle
    repeat (3) cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    saved = flag_nzcv;
    cyc(1'b0, 4'h0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b1);
    chk("flush_no_we", flag_we, 1'b0);
    chk("flush_nzcv_kept", flag_nzcv, saved);
    chk("flush_cnt_clear", flags_busy, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
    chk("post_flush_we", flag_we, 1'b1);
    idle();

    // Reset while a transfer is pending
    repeat (2) cyc(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    alu_valid = 1'b1; alu_nzcv = 4'b0101;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_flag_we", flag_we, 1'b0);
    chk("arst_flag_nzcv", flag_nzcv, 4'b0000);
    chk("arst_busy", flags_busy, 1'b0);
    chk("arst_full", rsv_full, 1'b0);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    repeat (2) idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(1, 0)), 4'($urandom), 1'($urandom_range(1, 0)), 4'($urandom),
          1'($urandom_range(2, 0) == 0), 1'($urandom_range(7, 0) == 0),
          1'($urandom_range(15, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
